// File: rtl/vx_bitmanip_batcher_pkg.sv
// Shared types and batch search for the bitmanip warp batcher.
// Widths fall back to local defaults when the core config is absent.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef INST_BITMANIP_BITS
`define INST_BITMANIP_BITS 4
`endif

package VX_bitmanip_pkg;

    localparam int NT         = `NUM_THREADS;
    localparam int NL         = 2;
    localparam int B          = NT / NL;
    localparam int BATCH_BITS = $clog2(B + 1);

    localparam int UUID_W = `UUID_BITS;
    localparam int NW_W   = `NW_BITS;
    localparam int NR_W   = `NR_BITS;
    localparam int OP_W   = `INST_BITMANIP_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_COMMIT
    } state_e;

    // Lowest batch index >= from with any active lane, or B if none.
    function automatic logic [BATCH_BITS-1:0] next_active_batch(
        input logic [NT-1:0]         tmask,
        input logic [BATCH_BITS-1:0] from
    );
        logic [BATCH_BITS-1:0] r;
        r = BATCH_BITS'(B);
        for (int k = B - 1; k >= 0; k--) begin
            if (k >= int'(from) && tmask[k*NL +: NL] != '0) begin
                r = BATCH_BITS'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vx_bitmanip_batcher.sv
// Splits one warp-wide bitmanip request into narrow datapath batches,
// skipping empty batches, and reassembles a single full-width commit.
module vx_bitmanip_batcher
    import VX_bitmanip_pkg::*;
#(
    parameter int NUM_THREADS = NT,
    parameter int NUM_LANES   = NL
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [UUID_W-1:0]                 req_uuid,
    input  logic [NW_W-1:0]                   req_wid,
    input  logic [NUM_THREADS-1:0]            req_tmask,
    input  logic [31:0]                       req_PC,
    input  logic [NR_W-1:0]                   req_rd,
    input  logic                              req_wb,
    input  logic [OP_W-1:0]                   req_op_type,
    input  logic                              req_use_imm,
    input  logic [31:0]                       req_imm,
    input  logic [NUM_THREADS-1:0][31:0]      req_rs1_data,
    input  logic [NUM_THREADS-1:0][31:0]      req_rs2_data,

    output logic                              exe_valid,
    input  logic                              exe_ready,
    output logic [OP_W-1:0]                   exe_op_type,
    output logic                              exe_use_imm,
    output logic [31:0]                       exe_imm,
    output logic [NUM_LANES-1:0]              exe_tmask,
    output logic [NUM_LANES-1:0][31:0]        exe_rs1_data,
    output logic [NUM_LANES-1:0][31:0]        exe_rs2_data,

    input  logic                              rsp_valid,
    output logic                              rsp_ready,
    input  logic [NUM_LANES-1:0][31:0]        rsp_data,

    output logic                              commit_valid,
    input  logic                              commit_ready,
    output logic [UUID_W-1:0]                 commit_uuid,
    output logic [NW_W-1:0]                   commit_wid,
    output logic [NUM_THREADS-1:0]            commit_tmask,
    output logic [31:0]                       commit_PC,
    output logic [NR_W-1:0]                   commit_rd,
    output logic                              commit_wb,
    output logic [NUM_THREADS-1:0][31:0]      commit_data,
    output logic                              commit_eop
);

    localparam logic [BATCH_BITS-1:0] B_IDX = BATCH_BITS'(B);

    state_e                         state_q;
    logic [BATCH_BITS-1:0]          iptr_q, rptr_q;
    logic [UUID_W-1:0]              uuid_q;
    logic [NW_W-1:0]                wid_q;
    logic [NUM_THREADS-1:0]         tmask_q;
    logic [31:0]                    pc_q;
    logic [NR_W-1:0]                rd_q;
    logic                           wb_q;
    logic [OP_W-1:0]                op_q;
    logic                           use_imm_q;
    logic [31:0]                    imm_q;
    logic [NUM_THREADS-1:0][31:0]   rs1_q, rs2_q, data_q;

    logic [BATCH_BITS-1:0]          first_b, iptr_d, rptr_d;
    int                             ibase, rbase;
    logic                           exe_fire, rsp_fire;

    always_comb begin
        first_b = next_active_batch(req_tmask, '0);
        iptr_d  = next_active_batch(tmask_q, iptr_q + 1'b1);
        rptr_d  = next_active_batch(tmask_q, rptr_q + 1'b1);
        ibase   = (iptr_q < B_IDX) ? int'(iptr_q) * NUM_LANES : 0;
        rbase   = (rptr_q < B_IDX) ? int'(rptr_q) * NUM_LANES : 0;
        exe_tmask    = '0;
        exe_rs1_data = '0;
        exe_rs2_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            exe_tmask[l]    = tmask_q[ibase + l];
            exe_rs1_data[l] = rs1_q[ibase + l];
            exe_rs2_data[l] = rs2_q[ibase + l];
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign exe_valid = (state_q == ST_BUSY) && (iptr_q < B_IDX);
    assign rsp_ready = (state_q == ST_BUSY);
    assign exe_fire  = exe_valid && exe_ready;
    // A response is only legal while a batch is outstanding.
    assign rsp_fire  = rsp_valid && (state_q == ST_BUSY) && (rptr_q != iptr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            iptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        uuid_q    <= req_uuid;
                        wid_q     <= req_wid;
                        tmask_q   <= req_tmask;
                        pc_q      <= req_PC;
                        rd_q      <= req_rd;
                        wb_q      <= req_wb;
                        op_q      <= req_op_type;
                        use_imm_q <= req_use_imm;
                        imm_q     <= req_imm;
                        rs1_q     <= req_rs1_data;
                        rs2_q     <= req_rs2_data;
                        data_q    <= '0;
                        iptr_q    <= first_b;
                        rptr_q    <= first_b;
                        state_q   <= (req_tmask == '0) ? ST_COMMIT : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (exe_fire) begin
                        iptr_q <= iptr_d;
                    end
                    if (rsp_fire) begin
                        for (int l = 0; l < NUM_LANES; l++) begin
                            if (tmask_q[rbase + l]) begin
                                data_q[rbase + l] <= rsp_data[l];
                            end
                        end
                        rptr_q <= rptr_d;
                        if (rptr_d == B_IDX) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (commit_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign exe_op_type  = op_q;
    assign exe_use_imm  = use_imm_q;
    assign exe_imm      = imm_q;

    assign commit_valid = (state_q == ST_COMMIT);
    assign commit_uuid  = uuid_q;
    assign commit_wid   = wid_q;
    assign commit_tmask = tmask_q;
    assign commit_PC    = pc_q;
    assign commit_rd    = rd_q;
    assign commit_wb    = wb_q;
    assign commit_data  = data_q;
    assign commit_eop   = 1'b1;

    rsp_proto_a: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> (state_q == ST_BUSY && rptr_q != iptr_q));

endmodule

// File: doc/vx_bitmanip_batcher.md
# VX_bitmanip_batcher

Issue-side controller for the bitmanip datapath. Accepts one full-warp bitmanip request (`NUM_THREADS` lanes) and sequences it through a narrower datapath (`NUM_LANES` lanes) as successive batches, skipping batches whose thread mask is all zero. It reassembles the per-batch results and emits a single full-width commit. It sits between the dispatch stage and the commit arbiter, so the bitmanip datapath can be built narrower than the warp.

## Interface
- `NUM_THREADS`, default `` `NUM_THREADS ``: warp width.
- `NUM_LANES`, default 2: datapath width. Must divide `NUM_THREADS`. `B = NUM_THREADS/NUM_LANES` batches.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid`/`req_ready` in/out 1: dispatch handshake.
- `req_uuid` in `` `UUID_BITS ``, `req_wid` in `` `NW_BITS ``, `req_tmask` in `NUM_THREADS`, `req_PC` in 32, `req_rd` in `` `NR_BITS ``, `req_wb` in 1: instruction tags.
- `req_op_type` in `` `INST_BITMANIP_BITS ``, `req_use_imm` in 1, `req_imm` in 32: operation.
- `req_rs1_data`, `req_rs2_data` in `NUM_THREADS`×32: operands.
- `exe_valid`/`exe_ready` out/in 1: batch issue handshake to datapath.
- `exe_op_type`, `exe_use_imm`, `exe_imm` out: copies of the latched request.
- `exe_tmask` out `NUM_LANES`; `exe_rs1_data`, `exe_rs2_data` out `NUM_LANES`×32.
- `rsp_valid`/`rsp_ready` in/out 1; `rsp_data` in `NUM_LANES`×32: datapath results, in issue order.
- `commit_valid`/`commit_ready` out/in 1.
- `commit_uuid`, `commit_wid`, `commit_tmask`, `commit_PC`, `commit_rd`, `commit_wb` out: latched tags.
- `commit_data` out `NUM_THREADS`×32.
- `commit_eop` out 1: constant 1.

## Operation
- States: IDLE, BUSY, COMMIT. Reset forces IDLE.
- IDLE:
  - `req_ready=1` when reset is low.
  - On handshake, latch all request fields and clear the result buffer to 0.
  - `req_tmask==0` goes to COMMIT; otherwise go to BUSY with the issue pointer and the response pointer both set to the lowest active batch.
- Active batch k: `req_tmask[k*NUM_LANES +: NUM_LANES] != 0`.
- BUSY issue side:
  - `exe_valid=1` while issue pointer < B.
  - Payload is batch slice k of tmask/rs1/rs2.
  - On `exe_valid&exe_ready`, advance to the next active batch, or to B if none remain.
  - Payload is held stable while `exe_ready=0`.
- BUSY response side:
  - `rsp_ready=1` only in BUSY.
  - On `rsp_valid`, write `rsp_data` into buffer slice (response pointer) for lanes whose tmask bit is set. Masked lanes stay 0.
  - Advance the response pointer with the same skip rule.
  - When the last active batch response is written, go to COMMIT.
- Issue and response may both fire in the same cycle. Each pointer advances independently.
- COMMIT: `commit_valid=1` and all commit fields stable. On `commit_ready`, go to IDLE.
- `rsp_valid` outside BUSY, or more responses than issued batches, is a protocol error. Flag it with an assertion and ignore the response.
- Reset mid-operation: in-flight batches are dropped. The datapath is reset on the same `reset`.

## Timing
- Reset values: `exe_valid=0`, `commit_valid=0`, `rsp_ready=0`, `req_ready=0` while reset is high, state IDLE. Buffer and tags are don't-care.
- Request accepted in cycle t:
  - First `exe_valid` in t+1.
  - With a 1-cycle datapath and no backpressure, batches issue back to back.
  - `commit_valid` in t+A+2, where A is the number of active batches. For A=0, `commit_valid` in t+1.
- `req_ready` is 0 from t+1 until the cycle after the commit handshake. Throughput is one warp per A+3 cycles.
- All outputs are registered or state-decoded. There is no combinational path from `req_*` to `exe_*` or `commit_*`, nor from `commit_ready` to `req_ready`.

## Structure
- Shared package `VX_bitmanip_pkg`:
  - State enum.
  - Function `next_active_batch(tmask, from)` returning the index, or B if none.
  - Localparams `B` and `BATCH_BITS = $clog2(B+1)`.
- No sub-module. The batch search is the package function used by both pointers.
- The existing `VX_bitmanip_unit` is instantiated outside this block with `NUM_LANES` width.

## Test plan
Configuration: `NUM_THREADS=4`, `NUM_LANES=2`, 1-cycle datapath model.
1. ROL, tmask 4'b1111, rs1 all 32'h8000_0001, rs2 all 1 → two batches in t+1 and t+2, commit in t+4, all data 32'h0000_0003, eop=1.
2. tmask 4'b1100, same op → one issue in t+1 with `exe_tmask=2'b11` and rs1 from lanes 2,3. Commit in t+3 with lanes 0,1 = 0.
3. tmask 4'b0000 → no `exe_valid`. Commit in t+1 with data all 0 and tags equal to the request.
4. tmask 4'b0110 → batch0 `exe_tmask=2'b10`, batch1 `exe_tmask=2'b01`. commit_data lanes 0 and 3 are 0.
5. `exe_ready` low for 3 cycles on batch0 → payload held stable, commit in t+7. Separately, `commit_ready` low for 5 cycles → fields stable, `req_ready=0`, next request accepted the cycle after the handshake.
6. `reset` asserted in BUSY after the first issue → next cycle `exe_valid=0`, `commit_valid=0`. `req_ready=1` in the first cycle reset is low; a new request completes normally.
